// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the pipeline and a split read/write memory port.
// One request in flight; misaligned requests are answered without touching memory.
package mem_pkg;
    localparam logic [1:0] MEM_ACCESS_BYTE     = 2'b00;
    localparam logic [1:0] MEM_ACCESS_HALFWORD = 2'b01;
    localparam logic [1:0] MEM_ACCESS_WORD     = 2'b10;

    typedef struct packed {
        logic        store;
        logic        sext;
        logic [1:0]  acc;
        logic [31:0] addr;
        logic [31:0] data;
    } lsu_req_t;
endpackage

module mem_lsu
    import mem_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_store_i,
    input  logic        req_sext_i,
    input  logic [1:0]  req_acc_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_data_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    output logic        resp_misaligned_o,
    output logic        mem_r_en_o,
    output logic        mem_sext_o,
    output logic [1:0]  mem_acc_r_o,
    output logic [31:0] mem_addr_r_o,
    input  logic [31:0] mem_data_r_i,
    output logic        mem_wr_en_o,
    output logic [1:0]  mem_acc_w_o,
    output logic [31:0] mem_addr_w_o,
    output logic [31:0] mem_data_w_o,
    input  logic        mem_wr_ready_i
);

    typedef enum logic [2:0] {
        IDLE,
        LD_ADDR,
        LD_DATA,
        ST_REQ,
        ST_HOLD
    } state_t;

    state_t   state;
    state_t   state_nx;
    lsu_req_t r_req;
    logic     misaligned;
    logic     accept;

    assign accept = req_valid_i & req_ready_o;

    // Alignment decode of the incoming request.
    always_comb begin
        misaligned = 1'b0;
        unique case (1'b1)
            (req_acc_i == MEM_ACCESS_HALFWORD): misaligned = req_addr_i[0];
            (req_acc_i == MEM_ACCESS_WORD),
            (req_acc_i == 2'b11):               misaligned = |req_addr_i[1:0];
            default:                            misaligned = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and memory port drive; ports are idle outside their states.
    always_comb begin
        state_nx     = state;
        req_ready_o  = 1'b0;
        mem_r_en_o   = 1'b0;
        mem_sext_o   = 1'b0;
        mem_acc_r_o  = '0;
        mem_addr_r_o = '0;
        mem_wr_en_o  = 1'b0;
        mem_acc_w_o  = '0;
        mem_addr_w_o = '0;
        mem_data_w_o = '0;
        unique case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i && !misaligned) begin
                    state_nx = req_store_i ? ST_REQ : LD_ADDR;
                end
            end
            LD_ADDR, LD_DATA: begin
                mem_r_en_o   = !r_req.store;
                mem_sext_o   = r_req.sext;
                mem_acc_r_o  = r_req.acc;
                mem_addr_r_o = r_req.addr;
                state_nx     = (state == LD_ADDR) ? LD_DATA : IDLE;
            end
            ST_REQ, ST_HOLD: begin
                mem_wr_en_o  = (state == ST_REQ) && r_req.store;
                mem_acc_w_o  = r_req.acc;
                mem_addr_w_o = r_req.addr;
                mem_data_w_o = r_req.data;
                if (state == ST_HOLD) begin
                    state_nx = IDLE;
                end else if (mem_wr_ready_i) begin
                    state_nx = ST_HOLD;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request latch and registered one-cycle response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req             <= '0;
            resp_valid_o      <= 1'b0;
            resp_data_o       <= '0;
            resp_misaligned_o <= 1'b0;
        end else begin
            resp_valid_o      <= 1'b0;
            resp_data_o       <= '0;
            resp_misaligned_o <= 1'b0;
            if (accept) begin
                r_req <= '{store: req_store_i, sext: req_sext_i,
                           acc: req_acc_i, addr: req_addr_i,
                           data: req_data_i};
                if (misaligned) begin
                    resp_valid_o      <= 1'b1;
                    resp_misaligned_o <= 1'b1;
                end
            end
            if (state == LD_DATA) begin
                resp_valid_o <= 1'b1;
                resp_data_o  <= mem_data_r_i;
            end
            if (state == ST_HOLD) begin
                resp_valid_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed vectors for mem_lsu against a small byte-lane memory model.
// Table of single transactions plus reset-abort and back-to-back sequences.
module tb_mem_lsu;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic        req_sext = 1'b0;
    logic [1:0]  req_acc = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_mis;
    logic        mem_r_en;
    logic        mem_sext;
    logic [1:0]  mem_acc_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_data_r;
    logic        mem_wr_en;
    logic [1:0]  mem_acc_w;
    logic [31:0] mem_addr_w;
    logic [31:0] mem_data_w;
    logic        mem_wr_ready;

    int n_cmp = 0;
    int n_bad = 0;
    int stall_cfg = 0;
    int wr_cnt = 0;
    logic        pre_en = 1'b0;
    logic [31:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_store_i(req_store), .req_sext_i(req_sext),
        .req_acc_i(req_acc), .req_addr_i(req_addr),
        .req_data_i(req_data),
        .resp_valid_o(resp_valid), .resp_data_o(resp_data),
        .resp_misaligned_o(resp_mis),
        .mem_r_en_o(mem_r_en), .mem_sext_o(mem_sext),
        .mem_acc_r_o(mem_acc_r), .mem_addr_r_o(mem_addr_r),
        .mem_data_r_i(mem_data_r),
        .mem_wr_en_o(mem_wr_en), .mem_acc_w_o(mem_acc_w),
        .mem_addr_w_o(mem_addr_w), .mem_data_w_o(mem_data_w),
        .mem_wr_ready_i(mem_wr_ready)
    );

    assign mem_wr_ready = mem_wr_en && (wr_cnt >= stall_cfg);

    // Memory write side: preload port, byte-lane merge, stall counter.
    always @(posedge clk) begin
        wr_cnt <= mem_wr_en ? wr_cnt + 1 : 0;
        if (pre_en) begin
            mem[pre_addr[9:2]] <= pre_data;
        end else if (mem_wr_en && mem_wr_ready) begin
            case (mem_acc_w)
                MEM_ACCESS_BYTE:
                    mem[mem_addr_w[9:2]][8*mem_addr_w[1:0] +: 8] <= mem_data_w[7:0];
                MEM_ACCESS_HALFWORD:
                    mem[mem_addr_w[9:2]][16*mem_addr_w[1] +: 16] <= mem_data_w[15:0];
                default:
                    mem[mem_addr_w[9:2]] <= mem_data_w;
            endcase
        end
    end

    // Memory read side: lane select and optional sign extension.
    logic [31:0] rw;
    logic [31:0] rsh;
    always_comb begin
        mem_data_r = '0;
        rw  = mem[mem_addr_r[9:2]];
        rsh = rw >> {mem_addr_r[1:0], 3'b000};
        if (mem_r_en) begin
            case (mem_acc_r)
                MEM_ACCESS_BYTE:
                    mem_data_r = mem_sext ? {{24{rsh[7]}}, rsh[7:0]}
                                          : {24'h0, rsh[7:0]};
                MEM_ACCESS_HALFWORD:
                    mem_data_r = mem_sext ? {{16{rsh[15]}}, rsh[15:0]}
                                          : {16'h0, rsh[15:0]};
                default: mem_data_r = rw;
            endcase
        end
    end

    typedef struct {
        bit          pre;
        logic [31:0] pre_addr;
        logic [31:0] pre_word;
        bit          store;
        bit          sext;
        logic [1:0]  acc;
        logic [31:0] addr;
        logic [31:0] data;
        int          stall;
        bit          mis;
        logic [31:0] exp_data;
        int          lat;
        int          rc;
        int          wc;
    } vec_t;

    localparam int NV = 14;
    vec_t v [NV];

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    task automatic drive(input bit st, input bit sx, input logic [1:0] ac,
                         input logic [31:0] ad, input logic [31:0] da);
        req_store = st;
        req_sext  = sx;
        req_acc   = ac;
        req_addr  = ad;
        req_data  = da;
    endtask

    task automatic run(input int i);
        vec_t t;
        int rc, wc, ov, rbad, holdn, hbad, pulses, lat;
        logic [31:0] rdat;
        logic rmis;
        logic prev_w;
        t = v[i];
        rc = 0; wc = 0; ov = 0; rbad = 0; holdn = 0;
        hbad = 0; pulses = 0; lat = 0;
        rdat = '0; rmis = 1'b0; prev_w = 1'b0;
        if (t.pre) preload(t.pre_addr, t.pre_word);
        stall_cfg = t.stall;
        chk("ready", i, req_ready, 1);
        drive(t.store, t.sext, t.acc, t.addr, t.data);
        req_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            rc += int'(mem_r_en);
            wc += int'(mem_wr_en);
            if (mem_r_en && mem_wr_en) ov++;
            if (mem_r_en && (mem_addr_r !== t.addr ||
                mem_acc_r !== t.acc || mem_sext !== t.sext)) rbad++;
            if (prev_w && !mem_wr_en) begin
                holdn++;
                if (mem_addr_w !== t.addr || mem_data_w !== t.data ||
                    mem_acc_w !== t.acc) hbad++;
            end
            prev_w = mem_wr_en;
            if (resp_valid) begin
                pulses++;
                if (pulses == 1) begin
                    lat  = c;
                    rdat = resp_data;
                    rmis = resp_mis;
                end
            end
        end
        chk("pulses", i, pulses, 1);
        chk("latency", i, lat, t.lat);
        chk("data", i, rdat, t.exp_data);
        chk("misaligned", i, rmis, t.mis);
        chk("r_en_cycles", i, rc, t.rc);
        chk("wr_en_cycles", i, wc, t.wc);
        chk("overlap", i, ov, 0);
        chk("rd_port", i, rbad, 0);
        chk("hold_cycles", i, holdn, (t.store && !t.mis) ? 1 : 0);
        chk("hold_stable", i, hbad, 0);
    endtask

    initial begin
        int pulses, ov;
        v[0]  = '{1, 'h100, 'hDEADBEEF, 0, 0, MEM_ACCESS_WORD, 'h100, 0, 0, 0, 'hDEADBEEF, 3, 2, 0};
        v[1]  = '{1, 'h100, 'h80123456, 0, 1, MEM_ACCESS_BYTE, 'h103, 0, 0, 0, 'hFFFFFF80, 3, 2, 0};
        v[2]  = '{0, 0, 0, 0, 0, MEM_ACCESS_BYTE, 'h103, 0, 0, 0, 'h00000080, 3, 2, 0};
        v[3]  = '{0, 0, 0, 0, 1, MEM_ACCESS_HALFWORD, 'h102, 0, 0, 0, 'hFFFF8012, 3, 2, 0};
        v[4]  = '{0, 0, 0, 0, 1, MEM_ACCESS_HALFWORD, 'h100, 0, 0, 0, 'h00003456, 3, 2, 0};
        v[5]  = '{1, 'h200, 'h11112222, 1, 0, MEM_ACCESS_HALFWORD, 'h202, 'hABCD, 2, 0, 0, 5, 0, 3};
        v[6]  = '{0, 0, 0, 0, 0, MEM_ACCESS_HALFWORD, 'h202, 0, 0, 0, 'h0000ABCD, 3, 2, 0};
        v[7]  = '{0, 0, 0, 1, 0, MEM_ACCESS_BYTE, 'h201, 'h5A, 0, 0, 0, 3, 0, 1};
        v[8]  = '{0, 0, 0, 0, 0, MEM_ACCESS_WORD, 'h200, 0, 0, 0, 'hABCD5A22, 3, 2, 0};
        v[9]  = '{0, 0, 0, 0, 0, MEM_ACCESS_WORD, 'h101, 0, 0, 1, 0, 1, 0, 0};
        v[10] = '{0, 0, 0, 0, 1, MEM_ACCESS_HALFWORD, 'h103, 0, 0, 1, 0, 1, 0, 0};
        v[11] = '{0, 0, 0, 1, 0, MEM_ACCESS_WORD, 'h102, 'h12345678, 0, 1, 0, 1, 0, 0};
        v[12] = '{0, 0, 0, 0, 0, 2'b11, 'h105, 0, 0, 1, 0, 1, 0, 0};
        v[13] = '{0, 0, 0, 0, 1, MEM_ACCESS_BYTE, 'h101, 0, 0, 0, 'h00000034, 3, 2, 0};

        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 0, req_ready, 1);
        chk("rst_resp_valid", 0, resp_valid, 0);
        chk("rst_resp_data", 0, resp_data, 0);
        chk("rst_mis", 0, resp_mis, 0);
        chk("rst_r_en", 0, mem_r_en, 0);
        chk("rst_wr_en", 0, mem_wr_en, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) run(i);

        stall_cfg = 100;
        drive(1, 0, MEM_ACCESS_WORD, 'h400, 'h1);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_st_req", 0, mem_wr_en, 1);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, MEM_ACCESS_WORD, 'h100, 0);
        req_valid = 1'b1;
        @(negedge clk);
        chk("abort_wr_en", 0, mem_wr_en, 0);
        chk("abort_r_en", 0, mem_r_en, 0);
        chk("abort_resp", 0, resp_valid, 0);
        rst = 1'b0;
        req_valid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
            if (c == 0) begin
                chk("abort_ready", 0, req_ready, 1);
                chk("abort_ignored", 0, mem_r_en, 0);
            end
        end
        chk("abort_pulses", 0, pulses, 0);
        stall_cfg = 0;

        chk("b2b_ready", 0, req_ready, 1);
        drive(1, 0, MEM_ACCESS_WORD, 'h300, 'hCAFEF00D);
        req_valid = 1'b1;
        pulses = 0;
        ov = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) drive(0, 0, MEM_ACCESS_WORD, 'h300, 0);
            if (mem_r_en && mem_wr_en) ov++;
            if (resp_valid) pulses++;
            if (c == 3) begin
                chk("b2b_st_resp", 0, resp_valid, 1);
                chk("b2b_ready_on_resp", 0, req_ready, 1);
            end
            if (c == 4) begin
                chk("b2b_ld_accepted", 0, mem_r_en, 1);
                req_valid = 1'b0;
            end
            if (c == 6) begin
                chk("b2b_ld_resp", 0, resp_valid, 1);
                chk("b2b_ld_data", 0, resp_data, 'hCAFEF00D);
            end
        end
        chk("b2b_pulses", 0, pulses, 2);
        chk("b2b_overlap", 0, ov, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The block SHALL have no parameters; access codes SHALL come from the shared constants `MEM_ACCESS_BYTE`, `MEM_ACCESS_HALFWORD` and `MEM_ACCESS_WORD`.
REQ-002 clk_i  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 req_valid_i  in  1  pipeline load/store request valid.
REQ-005 req_ready_o  out  1  block can accept a request.
REQ-006 req_store_i  in  1  1 = store, 0 = load.
REQ-007 req_sext_i  in  1  sign-extend load result.
REQ-008 req_acc_i  in  2  access size code.
REQ-009 req_addr_i  in  32  byte address.
REQ-010 req_data_i  in  32  store data, right-aligned.
REQ-011 resp_valid_o  out  1  one-cycle completion pulse.
REQ-012 resp_data_o  out  32  load result; 0 for stores and faults.
REQ-013 resp_misaligned_o  out  1  request was rejected as misaligned.
REQ-014 mem_r_en_o, mem_sext_o (out 1), mem_acc_r_o (out 2), mem_addr_r_o (out 32), mem_data_r_i (in 32)  memory read port.
REQ-015 mem_wr_en_o (out 1), mem_acc_w_o (out 2), mem_addr_w_o, mem_data_w_o (out 32), mem_wr_ready_i (in 1)  memory write port.

Function
REQ-016 States SHALL be IDLE, LD_ADDR, LD_DATA, ST_REQ, ST_HOLD.
REQ-017 req_ready_o SHALL equal (state == IDLE) and SHALL NOT depend on req_valid_i.
REQ-018 On req_valid_i & req_ready_o the block SHALL latch store, sext, acc, addr and data into internal registers.
REQ-019 Misalignment checks: a halfword request with addr[0]=1 SHALL fault, and a word request or code 2'b11 with addr[1:0]!=0 SHALL fault.
REQ-020 On a fault the block SHALL issue no memory access, SHALL pulse resp_valid_o with resp_misaligned_o=1 and resp_data_o=0 one cycle after acceptance, and SHALL stay in IDLE.
REQ-021 Load path: IDLE to LD_ADDR to LD_DATA to IDLE.
REQ-022 In LD_ADDR and LD_DATA the block SHALL drive mem_r_en_o=1 and hold the latched address, access code and sext on the read port.
REQ-023 At the end of LD_DATA the block SHALL register mem_data_r_i into resp_data_o and pulse resp_valid_o for one cycle, 3 cycles after the acceptance edge.
REQ-024 Store path: IDLE to ST_REQ.
REQ-025 In ST_REQ the block SHALL assert mem_wr_en_o with the latched address, data and access code, and SHALL remain in ST_REQ while mem_wr_ready_i=0.
REQ-026 When ST_REQ sees mem_wr_ready_i=1 the block SHALL move to ST_HOLD.
REQ-027 In ST_HOLD the block SHALL drive mem_wr_en_o=0 and keep mem_addr_w_o, mem_data_w_o and mem_acc_w_o stable for the memory's write-pending cycle.
REQ-028 ST_HOLD SHALL go to IDLE and pulse resp_valid_o with resp_data_o=0 and resp_misaligned_o=0.
REQ-029 mem_r_en_o SHALL be 0 in ST_REQ and ST_HOLD.
REQ-030 The read and write ports SHALL never be active in the same cycle.
REQ-031 In IDLE all mem_* outputs SHALL be 0.
REQ-032 resp_valid_o SHALL be high for at most one cycle per accepted request, and the block SHALL hold at most one request in flight.
REQ-033 A new request MAY be accepted in the same cycle that resp_valid_o is high.

Reset
REQ-034 When rst_i=1 at a rising edge the block SHALL enter IDLE and clear resp_valid_o, resp_data_o, resp_misaligned_o and all latched request registers.
REQ-035 Reset SHALL take priority over any simultaneous request; req_valid_i SHALL be ignored during reset.
REQ-036 Reset during any load or store state SHALL abort the operation with no response pulse; mem_wr_en_o and mem_r_en_o SHALL be 0 in the cycle after reset.
REQ-037 The memory controller SHALL be reset together with this block.

Verification
REQ-038 Word load from addr 0x100 where the memory holds 0xDEADBEEF -> resp_valid_o at acceptance+3 with resp_data_o=0xDEADBEEF; mem_r_en_o high for exactly 2 cycles.
REQ-039 Signed byte load from addr 0x103 where the word holds 0x80123456 -> mem_acc_r_o=BYTE, mem_sext_o=1, resp_data_o=0xFFFFFF80.
REQ-040 Halfword store of 0xABCD to 0x202 with mem_wr_ready_i low for 2 cycles -> mem_wr_en_o held 3 cycles, then one ST_HOLD cycle with address and data stable, then resp_valid_o=1.
REQ-041 Word load from 0x101 -> resp_misaligned_o=1 and resp_data_o=0 on the next cycle, with no mem_r_en_o or mem_wr_en_o activity.
REQ-042 rst_i asserted during ST_REQ -> IDLE and mem_wr_en_o=0 on the next cycle, no resp_valid_o pulse, and req_ready_o=1 after rst_i falls.
REQ-043 Back-to-back requests with req_valid_i held high (store then load) -> the second request is accepted on the first response cycle, and the read and write ports never overlap.
